// File: rtl/dispense_cmd_initiator.sv
// Initiator for the dispenser's parallel command link: drives mode/amount lines and the candyflag strobe, then runs a four-phase handshake.
// Optional feature: define DISPENSE_CMD_RETRY_EN to retry (via GAP) after an ack-rise timeout, up to MAX_RETRY extra attempts.
module dispense_cmd_initiator #(
    parameter int SETUP_CYCLES    = 4,
    parameter int ACK_TIMEOUT     = 2080000,
    parameter int DISPENSE_CYCLES = 1040000,
    parameter int MAX_RETRY       = 2
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [2:0] req_mode,
    input  logic [1:0] req_amount,
    input  logic       req_dispense,
    output logic [2:0] teststate_o,
    output logic [1:0] stateamount_o,
    output logic       candyflag_o,
    input  logic       handshake_i,
    output logic       busy,
    output logic       done_pulse,
    output logic       error_pulse
);
    localparam int CNT_MAX = (SETUP_CYCLES > DISPENSE_CYCLES) ? SETUP_CYCLES : DISPENSE_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int TMO_W   = $clog2(ACK_TIMEOUT + 1);

    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] DISP_LAST  = CNT_W'(DISPENSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_SAT    = CNT_W'(CNT_MAX);
    localparam logic [TMO_W-1:0] TMO_LAST   = TMO_W'(ACK_TIMEOUT - 1);
    localparam logic [TMO_W-1:0] TMO_SAT    = TMO_W'(ACK_TIMEOUT);
`ifdef DISPENSE_CMD_RETRY_EN
    localparam logic [2:0]       RETRY_MAX  = 3'(MAX_RETRY);
`endif

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SETUP    = 3'd1,
        WAIT_ACK = 3'd2,
        DISPENSE = 3'd3,
        WAIT_REL = 3'd4
`ifdef DISPENSE_CMD_RETRY_EN
        , GAP    = 3'd5
`endif
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             dispense_q, dispense_d;
    logic             ack_meta_q, ack_meta_d;
    logic             ack_s_q, ack_s_d;
    logic [2:0]       teststate_q, teststate_d;
    logic [1:0]       amount_q, amount_d;
    logic             candy_q, candy_d;
    logic             busy_q, busy_d;
    logic             ready_q, ready_d;
    logic             done_q, done_d;
    logic             error_q, error_d;
`ifdef DISPENSE_CMD_RETRY_EN
    logic [2:0]       retry_q, retry_d;
`endif

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        state_d     = state_q;
        cnt_d       = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + 1'b1;
        tmo_d       = (tmo_q == TMO_SAT) ? tmo_q : tmo_q + 1'b1;
        dispense_d  = dispense_q;
        ack_meta_d  = handshake_i;
        ack_s_d     = ack_meta_q;
        teststate_d = teststate_q;
        amount_d    = amount_q;
        candy_d     = candy_q;
        busy_d      = 1'b1;
        ready_d     = 1'b0;
        done_d      = 1'b0;
        error_d     = 1'b0;
`ifdef DISPENSE_CMD_RETRY_EN
        retry_d     = retry_q;
`endif

        case (state_q)
            IDLE: begin
                busy_d  = 1'b0;
                ready_d = 1'b1;
                cnt_d   = '0;
                tmo_d   = '0;
`ifdef DISPENSE_CMD_RETRY_EN
                retry_d = '0;
`endif
                if (req_valid && ready_q) begin
                    if (req_dispense && req_amount == 2'b11) begin
                        error_d = 1'b1;
                    end else begin
                        teststate_d = req_mode;
                        amount_d    = req_amount;
                        dispense_d  = req_dispense;
                        busy_d      = 1'b1;
                        ready_d     = 1'b0;
                        state_d     = SETUP;
                    end
                end
            end
            SETUP: begin
                // The ack timer only runs while setup is complete but a stale ack is still high.
                if (cnt_q != SETUP_LAST) begin
                    tmo_d = '0;
                end else begin
                    cnt_d = cnt_q;
                    if (!dispense_q) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else if (!ack_s_q) begin
                        candy_d = 1'b1;
                        tmo_d   = '0;
                        state_d = WAIT_ACK;
                    end else if (tmo_q == TMO_LAST) begin
                        error_d = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            WAIT_ACK: begin
                if (ack_s_q) begin
                    cnt_d   = '0;
                    state_d = DISPENSE;
                end else if (tmo_q == TMO_LAST) begin
                    candy_d = 1'b0;
`ifdef DISPENSE_CMD_RETRY_EN
                    if (retry_q < RETRY_MAX) begin
                        retry_d = retry_q + 3'd1;
                        cnt_d   = '0;
                        state_d = GAP;
                    end else begin
                        error_d = 1'b1;
                        state_d = IDLE;
                    end
`else
                    error_d = 1'b1;
                    state_d = IDLE;
`endif
                end
            end
`ifdef DISPENSE_CMD_RETRY_EN
            GAP: begin
                if (cnt_q == SETUP_LAST) begin
                    candy_d = 1'b1;
                    tmo_d   = '0;
                    state_d = WAIT_ACK;
                end
            end
`endif
            DISPENSE: begin
                if (cnt_q == DISP_LAST) begin
                    candy_d = 1'b0;
                    tmo_d   = '0;
                    state_d = WAIT_REL;
                end
            end
            WAIT_REL: begin
                if (!ack_s_q) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if (tmo_q == TMO_LAST) begin
                    error_d = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            tmo_q       <= '0;
            dispense_q  <= 1'b0;
            ack_meta_q  <= 1'b0;
            ack_s_q     <= 1'b0;
            teststate_q <= 3'b000;
            amount_q    <= 2'b00;
            candy_q     <= 1'b0;
            busy_q      <= 1'b0;
            ready_q     <= 1'b1;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
`ifdef DISPENSE_CMD_RETRY_EN
            retry_q     <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            tmo_q       <= tmo_d;
            dispense_q  <= dispense_d;
            ack_meta_q  <= ack_meta_d;
            ack_s_q     <= ack_s_d;
            teststate_q <= teststate_d;
            amount_q    <= amount_d;
            candy_q     <= candy_d;
            busy_q      <= busy_d;
            ready_q     <= ready_d;
            done_q      <= done_d;
            error_q     <= error_d;
`ifdef DISPENSE_CMD_RETRY_EN
            retry_q     <= retry_d;
`endif
        end
    end

    assign req_ready     = ready_q;
    assign teststate_o   = teststate_q;
    assign stateamount_o = amount_q;
    assign candyflag_o   = candy_q;
    assign busy          = busy_q;
    assign done_pulse    = done_q;
    assign error_pulse   = error_q;
endmodule

// File: tb/tb_dispense_cmd_initiator.sv
// Bench for dispense_cmd_initiator: directed and random transactions against a responder model;
// expected event cycles are derived arithmetically from the link's timing rules.
module tb_dispense_cmd_initiator;
    localparam int SETUP  = 4;
    localparam int ACK_TO = 20;
    localparam int DISP   = 8;
    localparam int RETRY  = 2;
    localparam int BUDGET = 200;
`ifdef DISPENSE_CMD_RETRY_EN
    localparam int WINDOWS = RETRY + 1;
`else
    localparam int WINDOWS = 1;
`endif

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [2:0] req_mode = 3'b000;
    logic [1:0] req_amount = 2'b00;
    logic       req_dispense = 1'b0;
    logic [2:0] teststate_o;
    logic [1:0] stateamount_o;
    logic       candyflag_o;
    logic       handshake_i = 1'b0;
    logic       busy;
    logic       done_pulse;
    logic       error_pulse;

    int         checks = 0;
    int         errors = 0;
    logic [2:0] last_mode = 3'b000;
    logic [1:0] last_amt = 2'b00;

    dispense_cmd_initiator #(
        .SETUP_CYCLES(SETUP),
        .ACK_TIMEOUT(ACK_TO),
        .DISPENSE_CYCLES(DISP),
        .MAX_RETRY(RETRY)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_mode(req_mode),
        .req_amount(req_amount),
        .req_dispense(req_dispense),
        .teststate_o(teststate_o),
        .stateamount_o(stateamount_o),
        .candyflag_o(candyflag_o),
        .handshake_i(handshake_i),
        .busy(busy),
        .done_pulse(done_pulse),
        .error_pulse(error_pulse)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (req_ready !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        check($sformatf("%s ready before request", tag), req_ready, 1'b1);
    endtask

    task automatic cmp_q(input string tag, input int obs[$], input int exp[$]);
        check($sformatf("%s count", tag), obs.size(), exp.size());
        for (int i = 0; i < obs.size() && i < exp.size(); i++)
            check($sformatf("%s[%0d] cycle", tag, i), obs[i], exp[i]);
    endtask

    // dr < 0: responder never acks. stale: handshake is held high by the caller throughout.
    task automatic run_txn(input string tag, input logic [2:0] mode, input logic [1:0] amt,
                           input logic disp, input int dr, input int df, input bit stale);
        int   rises[$], falls[$], dones[$], errs[$];
        int   e_rises[$], e_falls[$], e_dones[$], e_errs[$];
        bit   illegal;
        int   r_first, f_ack, end_k, base, fall;
        logic prev_candy;

        illegal = disp && (amt == 2'b11);
        if (illegal) begin
            e_errs.push_back(1);
        end else if (!disp) begin
            e_dones.push_back(SETUP + 1);
        end else if (stale) begin
            e_errs.push_back(SETUP + ACK_TO);
        end else if (dr >= 0 && dr <= ACK_TO - 3) begin
            fall = SETUP + 1 + dr + 3 + DISP;
            e_rises.push_back(SETUP + 1);
            e_falls.push_back(fall);
            if (df <= ACK_TO - 3) e_dones.push_back(fall + df + 3);
            else e_errs.push_back(fall + ACK_TO);
        end else begin
            for (int i = 0; i < WINDOWS; i++) begin
                base = SETUP + 1 + i * (ACK_TO + SETUP);
                e_rises.push_back(base);
                e_falls.push_back(base + ACK_TO);
            end
            e_errs.push_back(e_falls[e_falls.size() - 1]);
        end
        if (!illegal) begin
            last_mode = mode;
            last_amt  = amt;
        end

        wait_ready(tag);
        req_mode     = mode;
        req_amount   = amt;
        req_dispense = disp;
        req_valid    = 1'b1;
        prev_candy   = candyflag_o;
        r_first      = -1;
        f_ack        = -1;
        end_k        = -1;
        for (int k = 1; k <= BUDGET; k++) begin
            step();
            req_valid = 1'b0;
            if (k == 1) begin
                check($sformatf("%s busy at T+1", tag), busy, !illegal);
                check($sformatf("%s ready at T+1", tag), req_ready, illegal);
                check($sformatf("%s mode lines at T+1", tag), teststate_o, last_mode);
            end
            if (candyflag_o && !prev_candy) begin
                rises.push_back(k);
                if (r_first < 0) r_first = k;
            end
            if (!candyflag_o && prev_candy) begin
                falls.push_back(k);
                if (handshake_i && f_ack < 0) f_ack = k;
            end
            prev_candy = candyflag_o;
            if (done_pulse) dones.push_back(k);
            if (error_pulse) errs.push_back(k);
            if (end_k >= 0 && k == end_k + 1) begin
                check($sformatf("%s busy after end", tag), busy, 1'b0);
                check($sformatf("%s ready after end", tag), req_ready, 1'b1);
            end
            if ((done_pulse || error_pulse) && end_k < 0) end_k = k;
            if (!stale && dr >= 0 && r_first >= 0 && k == r_first + dr) handshake_i = 1'b1;
            if (!stale && f_ack >= 0 && k == f_ack + df) handshake_i = 1'b0;
            if (end_k >= 0 && k > end_k && (stale || !handshake_i)) break;
        end
        check($sformatf("%s completed within budget", tag), end_k >= 0, 1'b1);
        cmp_q($sformatf("%s candy rise", tag), rises, e_rises);
        cmp_q($sformatf("%s candy fall", tag), falls, e_falls);
        cmp_q($sformatf("%s done_pulse", tag), dones, e_dones);
        cmp_q($sformatf("%s error_pulse", tag), errs, e_errs);
        check($sformatf("%s teststate_o final", tag), teststate_o, last_mode);
        check($sformatf("%s stateamount_o final", tag), stateamount_o, last_amt);
    endtask

    initial begin
        int         n;
        logic [2:0] m;
        logic [1:0] a;
        logic       d;
        int         dr;
        int         df;

        #23;
        check("reset teststate_o", teststate_o, 3'b000);
        check("reset stateamount_o", stateamount_o, 2'b00);
        check("reset candyflag_o", candyflag_o, 1'b0);
        check("reset busy", busy, 1'b0);
        check("reset done_pulse", done_pulse, 1'b0);
        check("reset error_pulse", error_pulse, 1'b0);
        check("reset req_ready", req_ready, 1'b1);
        rstn = 1'b1;
        step();

        run_txn("mode_only", 3'b011, 2'b00, 1'b0, 0, 0, 1'b0);
        run_txn("dispense", 3'b101, 2'b01, 1'b1, 3, 3, 1'b0);
        run_txn("no_ack", 3'b010, 2'b10, 1'b1, -1, 0, 1'b0);
        run_txn("illegal_amount", 3'b111, 2'b11, 1'b1, 0, 0, 1'b0);

        handshake_i = 1'b1;
        repeat (3) step();
        run_txn("stale_ack", 3'b100, 2'b00, 1'b1, 0, 0, 1'b1);
        handshake_i = 1'b0;
        repeat (3) step();

        run_txn("ack_at_timeout", 3'b001, 2'b10, 1'b1, ACK_TO - 3, 0, 1'b0);
        run_txn("release_timeout", 3'b110, 2'b01, 1'b1, 0, ACK_TO - 2, 1'b0);

        // Asynchronous reset while candyflag_o is held high in DISPENSE.
        wait_ready("reset_mid");
        req_mode     = 3'b110;
        req_amount   = 2'b10;
        req_dispense = 1'b1;
        req_valid    = 1'b1;
        step();
        req_valid = 1'b0;
        n = 0;
        while (!candyflag_o && n < 20) begin
            step();
            n++;
        end
        check("reset_mid candy rose", candyflag_o, 1'b1);
        handshake_i = 1'b1;
        repeat (6) step();
        check("reset_mid candy held", candyflag_o, 1'b1);
        check("reset_mid busy held", busy, 1'b1);
        #2 rstn = 1'b0;
        #1;
        check("reset_mid candyflag_o", candyflag_o, 1'b0);
        check("reset_mid teststate_o", teststate_o, 3'b000);
        check("reset_mid stateamount_o", stateamount_o, 2'b00);
        check("reset_mid busy", busy, 1'b0);
        check("reset_mid req_ready", req_ready, 1'b1);
        handshake_i = 1'b0;
        last_mode   = 3'b000;
        last_amt    = 2'b00;
        repeat (3) step();
        #3 rstn = 1'b1;
        step();
        run_txn("after_reset", 3'b001, 2'b00, 1'b1, 2, 1, 1'b0);

        for (int i = 0; i < 12; i++) begin
            m  = 3'($urandom);
            a  = 2'($urandom);
            d  = ($urandom_range(0, 3) != 0);
            dr = ($urandom_range(0, 4) == 0) ? -1 : int'($urandom_range(0, ACK_TO - 3));
            df = ($urandom_range(0, 5) == 0) ? int'($urandom_range(ACK_TO - 2, ACK_TO + 2))
                                             : int'($urandom_range(0, ACK_TO - 3));
            repeat ($urandom_range(0, 3)) step();
            run_txn($sformatf("rand%0d", i), m, a, d, dr, df, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
